// File: rtl/booth_mult.sv
// Iterative 32-bit signed radix-2 Booth multiplier with a shared 32-bit CLA.
// Result is the low 32 bits of A*B; exception flags a product needing >32 bits.

// 4-bit carry-lookahead block: all internal carries are computed from cin in parallel
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  // generate/propagate and flattened lookahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end
endmodule

// 32-bit adder: eight lookahead blocks chained block-to-block
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] c;
  assign c[0] = cin;
  assign cout = c[8];

  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_blk
      cla4 u_blk (
        .a   (a[4*k+3:4*k]),
        .b   (b[4*k+3:4*k]),
        .cin (c[k]),
        .sum (sum[4*k+3:4*k]),
        .cout(c[k+1])
      );
    end
  endgenerate
endmodule

module booth_mult (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_mult,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nx;
  logic [31:0] m, hi, lo;
  logic        qm1;
  logic [4:0]  cnt;

  logic [31:0] addend, sum;
  logic        c0, ovf, add_cout_unused;

  // Booth recode of {LO[0],Qm1}: subtract is ~M with carry-in
  always_comb begin
    addend = 32'd0;
    c0     = 1'b0;
    case ({lo[0], qm1})
      2'b01:   addend = m;
      2'b10: begin addend = ~m; c0 = 1'b1; end
      default: ;
    endcase
  end

  cla32 u_add (
    .a   (hi),
    .b   (addend),
    .cin (c0),
    .sum (sum),
    .cout(add_cout_unused)
  );

  // S[31] is wrong when the add overflowed; flip it to shift in the true sign
  assign ovf = (hi[31] == addend[31]) && (sum[31] != hi[31]);

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next state: a start wins from any state, aborting any run in flight
  always_comb begin
    state_nx = state;
    if (ctrl_mult) state_nx = RUN;
    else begin
      case (state)
        RUN:     if (cnt == 5'd31) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // status outputs decoded straight from state
  always_comb begin
    busy           = (state == RUN);
    data_resultRDY = (state == DONE);
  end

  // datapath: operand capture, one add/shift per RUN cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m   <= '0;
      hi  <= '0;
      lo  <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
    end else if (ctrl_mult) begin
      m   <= data_operandA;
      hi  <= '0;
      lo  <= data_operandB;
      qm1 <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      hi  <= {sum[31] ^ ovf, sum[31:1]};
      lo  <= {sum[0], lo[31:1]};
      qm1 <= lo[0];
      cnt <= cnt + 5'd1;
    end
  end

  // result latch on the DONE edge, even if a restart lands on the same edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (state == DONE) begin
      data_result    <= lo;
      data_exception <= (hi != {32{lo[31]}});
    end
  end
endmodule

// File: tb/tb_booth_mult.sv
// Directed-vector bench for booth_mult: latency, results, overflow,
// restart, async reset and back-to-back issue.
module tb_booth_mult;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0, failures = 0;

  booth_mult dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_mult     (ctrl_mult),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // issue a one-cycle start; returns at the negedge after the start edge
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a; data_operandB = b; ctrl_mult = 1'b1;
    @(negedge clock);
    ctrl_mult = 1'b0;
  endtask

  // count edges until RDY (bounded); also count cycles busy was seen high
  task automatic wait_rdy(output int n, output int nbusy);
    n = 0;
    nbusy = busy ? 1 : 0;
    while (!data_resultRDY && n < 100) begin
      @(negedge clock);
      n++;
      if (busy) nbusy++;
    end
  endtask

  // full operation: start, wait, check latency and RDY width, then result
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc);
    int n, nb;
    start(a, b);
    wait_rdy(n, nb);
    chk({tag, "_latency"}, n, 32);
    @(negedge clock);
    chk({tag, "_rdy_width"}, {31'd0, data_resultRDY}, 0);
    chk({tag, "_result"}, data_result, exp_res);
    chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
  endtask

  initial begin
    int n, nb, rdy_seen;

    // reset state
    #12;
    chk("rst_result", data_result, 0);
    chk("rst_exc", {31'd0, data_exception}, 0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // 3*5 with busy-duration check
    start(32'd3, 32'd5);
    wait_rdy(n, nb);
    chk("m3x5_latency", n, 32);
    chk("m3x5_busy_cycles", nb, 32);
    chk("m3x5_busy_low_at_rdy", {31'd0, busy}, 0);
    @(negedge clock);
    chk("m3x5_rdy_width", {31'd0, data_resultRDY}, 0);
    chk("m3x5_result", data_result, 32'h0000000F);
    chk("m3x5_exc", {31'd0, data_exception}, 0);

    run_op("neg7x6",    32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0);
    run_op("max_x1",    32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0);
    run_op("min_xneg1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("p16xp16",   32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    run_op("min_xmin",  32'h80000000, 32'h80000000, 32'h00000000, 1'b1);

    // restart mid-run: only the second operation reports
    start(32'd3, 32'd5);
    rdy_seen = 0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    start(32'd2, 32'd2);
    if (data_resultRDY) rdy_seen++;
    chk("restart_no_early_rdy", rdy_seen, 0);
    wait_rdy(n, nb);
    chk("restart_latency", n, 32);
    @(negedge clock);
    chk("restart_result", data_result, 32'h00000004);
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    chk("restart_single_rdy", rdy_seen, 0);

    // async reset at iteration 15 clears outputs immediately
    start(32'd9, 32'd9);
    repeat (14) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_result", data_result, 0);
    chk("midrst_exc", {31'd0, data_exception}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_rdy", {31'd0, data_resultRDY}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) rdy_seen++;
    end
    chk("midrst_no_rdy_after", rdy_seen, 0);
    run_op("m9x9", 32'd9, 32'd9, 32'h00000051, 1'b0);

    // back-to-back: next start issued on the DONE cycle
    start(32'd4, 32'd4);
    wait_rdy(n, nb);
    chk("b2b_first_latency", n, 32);
    data_operandA = 32'hFFFFFFFF; data_operandB = 32'hFFFFFFFF; ctrl_mult = 1'b1;
    @(negedge clock);
    ctrl_mult = 1'b0;
    chk("b2b_first_result", data_result, 32'h00000010);
    chk("b2b_busy_after_restart", {31'd0, busy}, 1);
    wait_rdy(n, nb);
    chk("b2b_second_spacing", n + 1, 33);
    @(negedge clock);
    chk("b2b_second_result", data_result, 32'h00000001);
    chk("b2b_second_exc", {31'd0, data_exception}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_mult.md
# booth_mult

Iterative 32-bit signed multiplier for the processor's mult/div unit, using radix-2 Booth recoding. Each cycle it produces one partial-sum addend and drives it, with the running upper product, into one 32-bit carry-lookahead adder instance. The block sequences operand capture, 32 add/shift iterations and result/exception reporting. The execute stage consumes the low 32 bits of the product.

## Interface
- No parameters. Width is fixed at 32 to match the adder.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_mult  in  1  start pulse; operands are sampled on the rising edge where this is high.
- data_operandA  in  32  multiplicand M, two's complement.
- data_operandB  in  32  multiplier Q, two's complement.
- data_result  out  32  low 32 bits of A*B. Registered; held until the next start.
- data_exception  out  1  high when the signed 64-bit product does not fit in 32 bits. Registered; held with data_result.
- data_resultRDY  out  1  one-cycle pulse marking a valid result.
- busy  out  1  high while iterating.

## Operation
- Registers:
  - M (32): multiplicand.
  - HI (32) and LO (32): the product.
  - Qm1 (1): Booth extra bit.
  - cnt (5): iteration counter.
  - state: IDLE, RUN, DONE.
- Start: on an edge with ctrl_mult=1, from any state:
  - M←A, HI←0, LO←B, Qm1←0, cnt←0, state←RUN.
  - data_result and data_exception are not cleared until completion.
- Each RUN edge, select by {LO[0],Qm1}:
  - 00 or 11: addend 0, C0=0.
  - 01: addend M, C0=0.
  - 10: addend ~M, C0=1 (subtract M).
- Adder S = HI + addend + C0. Overflow ovf = (HI[31]==addend[31]) && (S[31]!=HI[31]).
- Arithmetic shift right of {S,LO,Qm1} by 1, with the shifted-in MSB = S[31]^ovf (true sign):
  - HI←{S[31]^ovf, S[31:1]}.
  - LO←{S[0], LO[31:1]}.
  - Qm1←LO[0].
- Counter: cnt←cnt+1. When cnt==31 before the increment, state←DONE (cnt wraps to 0).
- DONE (one cycle):
  - data_result←LO.
  - data_exception←(HI != {32{LO[31]}}).
  - state←IDLE.
- Outputs:
  - data_resultRDY is high exactly while state==DONE.
  - busy is high exactly while state==RUN.
- A new ctrl_mult during RUN aborts the current operation and restarts with the new operands. No RDY pulse is produced for the aborted one.
- A new ctrl_mult while in DONE: the DONE-edge result update and the restart both occur on the same edge. RDY is high for that cycle only.

## Timing
- Reset (reset_n=0, immediate, independent of clock):
  - state=IDLE, all registers 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Reset mid-operation discards the operation. No RDY pulse follows release.
- Latency: start edge E0; iterations on E1..E32; data_resultRDY and busy=0 visible after E32. The DONE-update edge E33 latches data_result/data_exception and drops RDY.
- Handshake: the consumer samples data_result on the edge after it sees RDY high, or any time later until the next start. Values are stable from E33 onward.
- Back-to-back: the next start may be issued on E33 (DONE) at the earliest, giving one result every 33 cycles.
- ctrl_mult held high for several cycles restarts on every high edge. Only the last start produces a result.
- Critical path: mux select → 32-bit CLA → shift register. The path must close in one clock.

## Test plan
- 3*5 → RDY exactly one cycle, 32 edges after the start edge; data_result=0x0000000F; exception=0; busy high for 32 cycles.
- -7*6 (0xFFFFFFF9, 0x00000006) → result 0xFFFFFFD6, exception=0. Repeat with 0x7FFFFFFF*1 → 0x7FFFFFFF, exception=0.
- Overflow:
  - 0x80000000*0xFFFFFFFF → result 0x80000000, exception=1.
  - 0x00010000*0x00010000 → result 0x00000000, exception=1.
  - 0x80000000*0x80000000 → result 0x00000000, exception=1 (checks ovf sign correction).
- Restart: start 3*5; 10 cycles later start 2*2 → a single RDY, 32 edges after the second start; result 0x00000004.
- Reset: start 9*9; assert reset_n=0 at iteration 15 for 2 cycles → all outputs 0 immediately; no RDY afterward. A subsequent 9*9 → 0x00000051.
- Back-to-back: issue the next start (−1*−1) on the DONE cycle of 4*4 → RDY pulses with results 0x10 then 0x1, 33 cycles apart.
